// File: rtl/dorv_pipe_pkg.sv
// Shared types and constants for dOrv32 pipeline stage boundary registers.
package dorv_pipe_pkg;

  // Encoding is {skid_valid, main_valid} so each handshake output is a state bit.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    TWO   = 2'b11
  } stage_state_e;

  localparam logic [31:0] NOP = 32'h0000_0013;

  localparam int PERF_CNT_W = 32;

endpackage

// File: rtl/pipe_perf_cnt.sv
// Saturating event counter with increment enable and synchronous clear.
// Only built when PIPE_SKID_REG_PERF_EN is defined.
`ifdef PIPE_SKID_REG_PERF_EN
module pipe_perf_cnt #(
  parameter int W = 32
) (
  input  logic         clock,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clock) begin
    if (clear) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule
`endif

// File: rtl/pipe_skid_reg.sv
// Pipeline stage register with 2-entry skid buffer and synchronous flush.
// Optional PIPE_SKID_REG_PERF_EN adds saturating stall/full counters.
module pipe_skid_reg
  import dorv_pipe_pkg::*;
#(
  parameter int          WIDTH       = 32,
  parameter logic [31:0] RESET_VALUE = NOP
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
`ifdef PIPE_SKID_REG_PERF_EN
  output logic [PERF_CNT_W-1:0] stall_cnt,
  output logic [PERF_CNT_W-1:0] full_cnt,
`endif
  output stage_state_e          state_dbg
);

  localparam logic [WIDTH-1:0] RST_V = WIDTH'(RESET_VALUE);

  // Handshake: a transfer happens on a rising edge where valid & ready are both
  // high; valid never depends on ready, and in_ready/out_valid are flop outputs.
  stage_state_e     state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             in_fire, out_fire;

  assign in_ready  = ~state_q[1];
  assign out_valid = state_q[0];
  assign out_data  = main_q;
  assign state_dbg = state_q;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= EMPTY;
      main_q  <= RST_V;
      skid_q  <= RST_V;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      // Accepted input in this cycle is dropped along with the stage contents.
      state_d = EMPTY;
      main_d  = RST_V;
    end else begin
      unique case (state_q)
        ONE: begin
          if (in_fire && out_fire) begin
            main_d = in_data;
          end else if (in_fire) begin
            state_d = TWO;
            skid_d  = in_data;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (out_fire) begin
            state_d = ONE;
            main_d  = skid_q;
          end
        end
        default: begin
          // EMPTY, and the unreachable {skid, !main} pattern behaves as EMPTY.
          if (in_fire) begin
            state_d = ONE;
            main_d  = in_data;
          end else begin
            state_d = EMPTY;
          end
        end
      endcase
    end
  end

`ifdef PIPE_SKID_REG_PERF_EN
  pipe_perf_cnt #(.W(PERF_CNT_W)) u_stall_cnt (
    .clock (clock),
    .clear (reset),
    .inc   (out_valid & ~out_ready),
    .cnt   (stall_cnt)
  );

  pipe_perf_cnt #(.W(PERF_CNT_W)) u_full_cnt (
    .clock (clock),
    .clear (reset),
    .inc   (state_q == TWO),
    .cnt   (full_cnt)
  );
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed bench for pipe_skid_reg; perf checks compiled under PIPE_SKID_REG_PERF_EN.
module tb_pipe_skid_reg;
  import dorv_pipe_pkg::*;

  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset, flush, in_valid, out_ready;
  logic         in_ready, out_valid;
  logic [W-1:0] in_data, out_data;
  stage_state_e state_dbg;
`ifdef PIPE_SKID_REG_PERF_EN
  logic [PERF_CNT_W-1:0] stall_cnt, full_cnt;
`endif

  int vectors     = 0;
  int miscompares = 0;

  // clock/reset block
  always #5 clock = ~clock;

  pipe_skid_reg #(.WIDTH(W)) dut (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
`ifdef PIPE_SKID_REG_PERF_EN
    .stall_cnt (stall_cnt),
    .full_cnt  (full_cnt),
`endif
    .state_dbg (state_dbg)
  );

  // driver tasks
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [W-1:0] d, input logic rdy);
    in_valid  = v;
    in_data   = d;
    out_ready = rdy;
  endtask

  // scoreboard comparison point
  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_stage(input string tag, input logic ov, input logic [W-1:0] od,
                           input logic ir);
    chk({tag, ".out_valid"}, W'(out_valid), W'(ov));
    chk({tag, ".out_data"},  out_data,      od);
    chk({tag, ".in_ready"},  W'(in_ready),  W'(ir));
  endtask

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    drive(1'b1, 32'hDEAD_BEEF, 1'b0);

    // Reset held 3 cycles with valid input: nothing accepted.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_stage("reset", 1'b0, 32'h13, 1'b1);
    end
    chk("reset.state", W'(state_dbg), W'(EMPTY));
    reset = 1'b0;
    drive(1'b0, 32'h0, 1'b0);
    tick();
    chk_stage("post_reset", 1'b0, 32'h13, 1'b1);

    // Streaming at full rate.
    drive(1'b1, 32'h1, 1'b1); tick(); chk_stage("stream1", 1'b1, 32'h1, 1'b1);
    drive(1'b1, 32'h2, 1'b1); tick(); chk_stage("stream2", 1'b1, 32'h2, 1'b1);
    drive(1'b1, 32'h3, 1'b1); tick(); chk_stage("stream3", 1'b1, 32'h3, 1'b1);
    drive(1'b0, 32'h0, 1'b1); tick(); chk_stage("stream_drain", 1'b0, 32'h3, 1'b1);

    // Back-pressure: A then B fill the stage, C is held off.
    drive(1'b1, 32'hA, 1'b0); tick(); chk_stage("bp_a", 1'b1, 32'hA, 1'b1);
    drive(1'b1, 32'hB, 1'b0); tick(); chk_stage("bp_b", 1'b1, 32'hA, 1'b0);
    chk("bp.state_two", W'(state_dbg), W'(TWO));
    drive(1'b1, 32'hC, 1'b0); tick(); chk_stage("bp_hold1", 1'b1, 32'hA, 1'b0);
    tick();                           chk_stage("bp_hold2", 1'b1, 32'hA, 1'b0);
    drive(1'b1, 32'hC, 1'b1); tick(); chk_stage("bp_out_b", 1'b1, 32'hB, 1'b1);
    tick();                           chk_stage("bp_out_c", 1'b1, 32'hC, 1'b1);
    drive(1'b0, 32'h0, 1'b1); tick(); chk_stage("bp_empty", 1'b0, 32'hC, 1'b1);

    // Flush in TWO with a pending input.
    drive(1'b1, 32'hA, 1'b0); tick();
    drive(1'b1, 32'hB, 1'b0); tick(); chk_stage("fl_two", 1'b1, 32'hA, 1'b0);
    flush = 1'b1;
    drive(1'b1, 32'hC, 1'b0); tick(); chk_stage("fl_two_kill", 1'b0, 32'h13, 1'b1);
    flush = 1'b0;
    drive(1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_stage("fl_two_quiet", 1'b0, 32'h13, 1'b1);
    end

    // Flush in ONE with a completing input handshake: both discarded.
    drive(1'b1, 32'hD, 1'b0); tick(); chk_stage("fl_one", 1'b1, 32'hD, 1'b1);
    flush = 1'b1;
    drive(1'b1, 32'hE, 1'b0); tick(); chk_stage("fl_one_kill", 1'b0, 32'h13, 1'b1);
    flush = 1'b0;
    drive(1'b0, 32'h0, 1'b1); tick(); chk_stage("fl_one_quiet", 1'b0, 32'h13, 1'b1);

    // Reset mid-operation from TWO.
    drive(1'b1, 32'h7, 1'b0); tick();
    drive(1'b1, 32'h8, 1'b0); tick(); chk_stage("rst_two", 1'b1, 32'h7, 1'b0);
    reset = 1'b1;
    tick(); chk_stage("rst_mid", 1'b0, 32'h13, 1'b1);
    reset = 1'b0;
    drive(1'b1, 32'h5, 1'b0); tick(); chk_stage("rst_next", 1'b1, 32'h5, 1'b1);
    drive(1'b0, 32'h0, 1'b1); tick(); chk_stage("rst_drain", 1'b0, 32'h5, 1'b1);

`ifdef PIPE_SKID_REG_PERF_EN
    // Counters clear on reset, survive flush, saturate.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("perf.stall_clr", stall_cnt, 32'h0);
    chk("perf.full_clr",  full_cnt,  32'h0);
    drive(1'b1, 32'h9, 1'b0); tick();
    drive(1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 7; i++) tick();
    chk("perf.stall7", stall_cnt, 32'd7);
    chk("perf.full0",  full_cnt,  32'd0);
    drive(1'b1, 32'h10, 1'b0); tick();
    drive(1'b0, 32'h0, 1'b0);
    tick(); tick();
    chk("perf.full2",   full_cnt,  32'd2);
    chk("perf.stall10", stall_cnt, 32'd10);
    flush = 1'b1; tick(); flush = 1'b0;
    chk("perf.flush_keep", stall_cnt, 32'd11);
    drive(1'b1, 32'h11, 1'b0); tick();
    drive(1'b0, 32'h0, 1'b0);
    force dut.u_stall_cnt.cnt = 32'hFFFF_FFFE;
    #1;
    release dut.u_stall_cnt.cnt;
    tick(); tick(); tick();
    chk("perf.stall_sat", stall_cnt, 32'hFFFF_FFFF);
`endif

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
